encode83_queue: RTL and testbench
=================================

# encode83_queue

Sequential 8-to-3 priority encoder with request capture: sticky-latches an 8-bit request vector, then emits the highest-priority pending index through a valid/ready handshake, one index per transfer. It sits on the encoder side of the 2-to-4/one-hot decode path, turning multi-source requests back into a binary index. A seven-segment output shows the last transferred index on the board.

## Interface
Parameters:
- none; width fixed at 8 requests / 3-bit index.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request bits; bit i high in a cycle requests index i.
- en  in  1  capture enable; low blocks new request capture; pending state and output keep operating.
- out_valid  out  1  out_idx holds a valid index.
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready at a rising edge.
- out_idx  out  3  index being offered; bit 7 is highest priority.
- pending  out  8  requests captured, not yet offered.
- dup_cnt  out  8  saturating count of dropped duplicate requests.
- seg  out  7  active-low {g,f,e,d,c,b,a} digit of the last transferred index.

## Operation
- Capture: each edge with en=1, pending_next = (pending & ~taken) | req. taken is the one-hot bit moved to the output that edge, or 0.
- Duplicate: a req bit already set in pending (before the taken clear) is merged. dup_cnt increments by the number of such bits that edge and saturates at 255. A req bit equal to the bit being taken that edge is not a duplicate; it is re-latched and served again later.
- Selection: highest set bit of the registered pending. Same-cycle req never bypasses to the output.
- FSM, 2 states:
  - IDLE: out_valid=0. If pending != 0, load out_idx = highest pending bit, clear that bit, go to SHOW.
  - SHOW: out_valid=1. out_idx is stable until transfer.
    - On transfer with pending != 0: load the next index in the same edge and stay in SHOW (back-to-back, 1 transfer/cycle).
    - On transfer with pending == 0: go to IDLE.
    - With no transfer: hold; pending keeps accumulating.
- Higher-priority requests arriving while in SHOW do not preempt the held index.
- seg updates on each transfer to the glyph of out_idx: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h.

## Timing
- Reset (rst high at an edge): state IDLE, pending=00h, out_valid=0, out_idx=0, dup_cnt=0, seg=7Fh (blank). rst overrides every same-edge event, including a handshake in progress. Requests sampled at the reset edge are discarded.
- Latency: req high at edge n, with IDLE and nothing higher pending → pending set after edge n → out_valid=1 after edge n+1.
- Throughput: one index per cycle while out_ready=1 and pending != 0.
- out_ready is ignored while out_valid=0. out_valid never deasserts without a transfer, except on reset.
- en=0: req is ignored entirely, with no capture and no dup counting. Draining continues.
- All outputs are registered; no combinational path from req or out_ready to any output.

## Structure
- Package encode83_pkg: FSM state typedef (IDLE, SHOW) and the eight seg glyph constants plus SEG_BLANK=7Fh.
- Sub-module bcd7seg: 3-bit index → 7-bit active-low glyph, combinational. Its output is registered in the parent on transfer.
- Priority select (highest set bit → index + one-hot) is a function in the package.

## Test plan
- Reset: drive req=FFh with rst high → all outputs at reset values and pending=00h after release.
- Single request: req=08h for one cycle, out_ready=1 → out_valid rises two edges later with out_idx=3. The transfer occurs, out_valid drops, and seg=30h.
- Priority drain: req=A5h for one cycle, out_ready=1 → indices 7,5,2,0 on four consecutive cycles, then IDLE. pending sequence is A5h→25h→05h→01h→00h.
- Back-pressure and no preempt: hold out_ready=0 with out_idx=2 offered, then pulse req=80h → out_idx stays 2. After out_ready=1, the next index is 7.
- Duplicates: with pending=10h, drive req=10h for 300 cycles while out_ready=0 → dup_cnt saturates at FFh and pending stays 10h.
- Re-request and enable: request bit 4 on the same edge it is taken → 4 is served twice. With en=0 and req=FFh → pending and dup_cnt are unchanged.

Source files
------------

// File: rtl/encode83_pkg.sv
// Shared types, seven-segment glyphs and the priority-select helper for encode83_queue.
package encode83_pkg;

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  // Active-low {g,f,e,d,c,b,a} glyphs for digits 0..7
  localparam logic [6:0] Seg0     = 7'h40;
  localparam logic [6:0] Seg1     = 7'h79;
  localparam logic [6:0] Seg2     = 7'h24;
  localparam logic [6:0] Seg3     = 7'h30;
  localparam logic [6:0] Seg4     = 7'h19;
  localparam logic [6:0] Seg5     = 7'h12;
  localparam logic [6:0] Seg6     = 7'h02;
  localparam logic [6:0] Seg7     = 7'h78;
  localparam logic [6:0] SegBlank = 7'h7f;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] onehot;
  } prio_t;

  // Highest set bit wins; ascending scan lets later (higher) bits overwrite.
  function automatic prio_t prio_sel(input logic [7:0] vec);
    prio_t r;
    r.idx    = '0;
    r.onehot = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        r.idx    = 3'(i);
        r.onehot = 8'(1) << i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational 3-bit index to active-low seven-segment glyph.
module bcd7seg
  import encode83_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    unique case (idx_i)
      3'd0: seg_o = Seg0;
      3'd1: seg_o = Seg1;
      3'd2: seg_o = Seg2;
      3'd3: seg_o = Seg3;
      3'd4: seg_o = Seg4;
      3'd5: seg_o = Seg5;
      3'd6: seg_o = Seg6;
      3'd7: seg_o = Seg7;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/encode83_queue.sv
// Sticky request capture feeding a valid/ready 8-to-3 priority encoder with a
// seven-segment display of the last transferred index.
module encode83_queue
  import encode83_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic [7:0] pending,
  output logic [7:0] dup_cnt,
  output logic [6:0] seg
);

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] dup_q, dup_d;
  logic [6:0] seg_q, seg_d;

  logic [6:0] glyph;
  prio_t      sel;
  logic       xfer, load;
  logic [7:0] taken, dup_bits;
  logic [3:0] dup_n;
  logic [8:0] dup_sum;

  bcd7seg u_bcd7seg (
    .idx_i(idx_q),
    .seg_o(glyph)
  );

  always_comb begin
    sel  = prio_sel(pending_q);
    xfer = (state_q == StShow) && out_ready;
    // A new index is loaded from idle or on the same edge as a transfer.
    load  = (pending_q != 8'h00) && ((state_q == StIdle) || xfer);
    taken = load ? sel.onehot : 8'h00;

    // The bit being taken this edge is re-latched, not counted as a duplicate.
    dup_bits = en ? (req & pending_q & ~taken) : 8'h00;
    dup_n    = '0;
    for (int i = 0; i < 8; i++) begin
      dup_n = dup_n + 4'(dup_bits[i]);
    end
    dup_sum = {1'b0, dup_q} + {5'b0, dup_n};
    dup_d   = dup_sum[8] ? 8'hff : dup_sum[7:0];

    pending_d = (pending_q & ~taken) | (en ? req : 8'h00);

    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    if (xfer) begin
      seg_d   = glyph;
      state_d = StIdle;
    end
    if (load) begin
      idx_d   = sel.idx;
      state_d = StShow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 8'h00;
      idx_q     <= 3'd0;
      dup_q     <= 8'h00;
      seg_q     <= SegBlank;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      dup_q     <= dup_d;
      seg_q     <= seg_d;
    end
  end

  assign out_valid = (state_q == StShow);
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign dup_cnt   = dup_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_encode83_queue.sv
// Directed and randomized bench for encode83_queue against a bit-list reference model.
module tb_encode83_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic [7:0] dup_cnt;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  // Reference model: a set of waiting indices, the offered index, a saturating tally.
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_idx;
  int       m_dup;
  bit [6:0] m_seg;
  bit [6:0] glyph_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  encode83_queue dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .pending  (pending),
    .dup_cnt  (dup_cnt),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit [7:0] rq, input bit e, input bit rd);
    int  taken;
    int  nd;
    bit  xf;
    xf = m_valid && rd;
    if (r) begin
      m_pend  = 8'h00;
      m_valid = 1'b0;
      m_idx   = 0;
      m_dup   = 0;
      m_seg   = 7'h7f;
    end else begin
      taken = -1;
      if (!m_valid || xf) begin
        for (int i = 7; i >= 0; i--) begin
          if (m_pend[i] && taken < 0) taken = i;
        end
      end
      if (xf) m_seg = glyph_tab[m_idx];
      nd = 0;
      if (e) begin
        for (int i = 0; i < 8; i++) begin
          if (rq[i] && m_pend[i] && i != taken) nd++;
        end
      end
      if (taken >= 0) m_pend[taken] = 1'b0;
      if (e) m_pend = m_pend | rq;
      if (taken >= 0) begin
        m_idx   = taken;
        m_valid = 1'b1;
      end else if (xf) begin
        m_valid = 1'b0;
      end
      m_dup = (m_dup + nd > 255) ? 255 : m_dup + nd;
    end
  endtask

  task automatic step(input bit r, input bit [7:0] rq, input bit e, input bit rd);
    rst       = r;
    req       = rq;
    en        = e;
    out_ready = rd;
    model_edge(r, rq, e, rd);
    @(posedge clk);
    #1;
    chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
    chk("out_idx", {5'b0, out_idx}, 8'(m_idx));
    chk("pending", pending, m_pend);
    chk("dup_cnt", dup_cnt, 8'(m_dup));
    chk("seg", {1'b0, seg}, {1'b0, m_seg});
  endtask

  initial begin
    // Reset with all requests asserted
    step(1, 8'hff, 1, 0);
    step(1, 8'hff, 1, 1);
    chk("rst_pending", pending, 8'h00);
    chk("rst_seg", {1'b0, seg}, 8'h7f);
    step(0, 8'h00, 1, 0);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);

    // Single request: two-edge latency then transfer
    step(0, 8'h08, 1, 1);
    chk("single_valid_n", {7'b0, out_valid}, 8'h00);
    step(0, 8'h00, 1, 1);
    chk("single_idx", {5'b0, out_idx}, 8'h03);
    step(0, 8'h00, 1, 1);
    chk("single_drop", {7'b0, out_valid}, 8'h00);
    chk("single_seg", {1'b0, seg}, 8'h30);

    // Priority drain 7,5,2,0
    step(0, 8'ha5, 1, 1);
    step(0, 8'h00, 1, 1);
    chk("drain_idx7", {5'b0, out_idx}, 8'h07);
    chk("drain_p25", pending, 8'h25);
    step(0, 8'h00, 1, 1);
    chk("drain_idx5", {5'b0, out_idx}, 8'h05);
    step(0, 8'h00, 1, 1);
    chk("drain_idx2", {5'b0, out_idx}, 8'h02);
    step(0, 8'h00, 1, 1);
    chk("drain_idx0", {5'b0, out_idx}, 8'h00);
    chk("drain_p00", pending, 8'h00);
    step(0, 8'h00, 1, 1);
    chk("drain_idle", {7'b0, out_valid}, 8'h00);

    // Back-pressure: higher request must not preempt index 2
    step(0, 8'h04, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h80, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("bp_hold", {5'b0, out_idx}, 8'h02);
    step(0, 8'h00, 1, 1);
    chk("bp_next", {5'b0, out_idx}, 8'h07);
    step(0, 8'h00, 1, 1);

    // Duplicate saturation
    step(0, 8'h01, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h10, 1, 0);
    for (int i = 0; i < 300; i++) step(0, 8'h10, 1, 0);
    chk("dup_sat", dup_cnt, 8'hff);
    chk("dup_pend", pending, 8'h10);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 1);
    step(1, 8'h00, 1, 0);

    // Re-request on the edge bit 4 is taken: served twice, not a duplicate
    step(0, 8'h10, 1, 0);
    step(0, 8'h10, 1, 0);
    chk("rereq_dup", dup_cnt, 8'h00);
    chk("rereq_pend", pending, 8'h10);
    step(0, 8'h00, 1, 1);
    chk("rereq_again", {5'b0, out_idx}, 8'h04);
    chk("rereq_seg", {1'b0, seg}, 8'h19);
    step(0, 8'h00, 1, 1);

    // Enable low: no capture, no duplicate counting
    step(0, 8'h02, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h40, 1, 0);
    step(0, 8'h40, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'hff, 0, 0);
    chk("en0_pend", pending, 8'h40);
    chk("en0_dup", dup_cnt, 8'h01);

    // Reset overrides a handshake in progress
    step(1, 8'hff, 1, 1);
    chk("rst_hs_valid", {7'b0, out_valid}, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), 8'($urandom & $urandom), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
